// File: rtl/measurement_sequencer.sv
// rtl/measurement_sequencer.sv - start-to-done sequencer for the ring-oscillator counter measurement
//
// Purpose: runs one measurement for each accepted start. The sequence is
// counter clear, a gate window of programmable length, a settle period,
// a one-cycle latch strobe and then a framed serial shift-out.
//
// Ports:
//   clk           system clock
//   rst_n         synchronous active-low reset
//   ena           design enable; when low, all state and outputs hold
//   start         measurement request, level-sampled in IDLE and DONE
//   abort         cancels a running measurement; takes priority over start
//   window_sel    gate length select, W = 2^(WINDOW_BASE_LOG2 + 2*window_sel)
//   ctr_reset     counter clear strobe
//   gate          counter gate window
//   latch_counter one-cycle load strobe for the readout shift register
//   frame_active  high while readout bits are shifted out
//   bit_index     current frame bit, FRAME_BITS-1 down to 0; 0 outside SHIFT
//   busy          measurement in progress
//   done          one-cycle completion pulse
module measurement_sequencer #(
    parameter int WINDOW_BASE_LOG2 = 8,
    parameter int SETTLE_CYCLES    = 4,
    parameter int FRAME_BITS       = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       start,
    input  logic       abort,
    input  logic [1:0] window_sel,
    output logic       ctr_reset,
    output logic       gate,
    output logic       latch_counter,
    output logic       frame_active,
    output logic [4:0] bit_index,
    output logic       busy,
    output logic       done
);

    // One shared down-counter times every multi-cycle phase. It is wide
    // enough to hold W-1 for the largest window.
    localparam int CW = WINDOW_BASE_LOG2 + 6;

    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] FRAME_LOAD  = CW'(FRAME_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_GATE,
        S_SETTLE,
        S_LATCH,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_wsel;

    logic          r_ctr_reset;
    logic          r_gate;
    logic          r_latch_counter;
    logic          r_frame_active;
    logic [4:0]    r_bit_index;
    logic          r_busy;
    logic          r_done;

    state_t        w_next_state;
    logic [CW-1:0] w_next_cnt;
    logic [1:0]    w_next_wsel;
    logic [CW:0]   w_win;
    logic [CW-1:0] w_win_m1;
    logic          w_in_busy;

    // W is computed one bit wider so that the largest window (2^CW) is
    // representable before the -1 brings it back into counter range.
    assign w_win    = (CW + 1)'(1) << (WINDOW_BASE_LOG2 + 2 * int'(r_wsel));
    assign w_win_m1 = CW'(w_win - (CW + 1)'(1));

    assign w_in_busy = (r_state == S_CLEAR) || (r_state == S_GATE) ||
                       (r_state == S_SETTLE) || (r_state == S_LATCH) ||
                       (r_state == S_SHIFT);

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_next_wsel  = r_wsel;

        if (abort && w_in_busy) begin
            w_next_state = S_IDLE;
            w_next_cnt   = '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start && !abort) begin
                        w_next_state = S_CLEAR;
                        w_next_cnt   = SETTLE_LOAD;
                        w_next_wsel  = window_sel;
                    end else begin
                        w_next_state = S_IDLE;
                        w_next_cnt   = '0;
                    end
                end
                S_CLEAR: begin
                    if (r_cnt == '0) begin
                        w_next_state = S_GATE;
                        w_next_cnt   = w_win_m1;
                    end else begin
                        w_next_cnt = r_cnt - CNT_ONE;
                    end
                end
                S_GATE: begin
                    if (r_cnt == '0) begin
                        w_next_state = S_SETTLE;
                        w_next_cnt   = SETTLE_LOAD;
                    end else begin
                        w_next_cnt = r_cnt - CNT_ONE;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == '0) begin
                        w_next_state = S_LATCH;
                        w_next_cnt   = '0;
                    end else begin
                        w_next_cnt = r_cnt - CNT_ONE;
                    end
                end
                S_LATCH: begin
                    w_next_state = S_SHIFT;
                    w_next_cnt   = FRAME_LOAD;
                end
                S_SHIFT: begin
                    if (r_cnt == '0) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_cnt = r_cnt - CNT_ONE;
                    end
                end
                default: begin
                    w_next_state = S_IDLE;
                    w_next_cnt   = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next-state decode so they line up
    // with the state register cycle for cycle. In SHIFT the counter itself
    // is the bit index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_wsel          <= '0;
            r_ctr_reset     <= 1'b0;
            r_gate          <= 1'b0;
            r_latch_counter <= 1'b0;
            r_frame_active  <= 1'b0;
            r_bit_index     <= '0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
        end else if (ena) begin
            r_state         <= w_next_state;
            r_cnt           <= w_next_cnt;
            r_wsel          <= w_next_wsel;
            r_ctr_reset     <= (w_next_state == S_CLEAR);
            r_gate          <= (w_next_state == S_GATE);
            r_latch_counter <= (w_next_state == S_LATCH);
            r_frame_active  <= (w_next_state == S_SHIFT);
            r_bit_index     <= (w_next_state == S_SHIFT) ? w_next_cnt[4:0] : 5'd0;
            r_busy          <= (w_next_state == S_CLEAR) || (w_next_state == S_GATE) ||
                               (w_next_state == S_SETTLE) || (w_next_state == S_LATCH) ||
                               (w_next_state == S_SHIFT);
            r_done          <= (w_next_state == S_DONE);
        end
    end

    assign ctr_reset     = r_ctr_reset;
    assign gate          = r_gate;
    assign latch_counter = r_latch_counter;
    assign frame_active  = r_frame_active;
    assign bit_index     = r_bit_index;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule

// File: tb/tb_measurement_sequencer.sv
// tb/tb_measurement_sequencer.sv - self-checking bench for measurement_sequencer
module tb_measurement_sequencer;

    localparam int S = 4;
    localparam int F = 24;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       start;
    logic       abort;
    logic [1:0] window_sel;
    logic       ctr_reset;
    logic       gate;
    logic       latch_counter;
    logic       frame_active;
    logic [4:0] bit_index;
    logic       busy;
    logic       done;

    int checks;
    int errors;

    logic [10:0] obs;
    assign obs = {ctr_reset, gate, latch_counter, frame_active, bit_index, busy, done};

    measurement_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .start        (start),
        .abort        (abort),
        .window_sel   (window_sel),
        .ctr_reset    (ctr_reset),
        .gate         (gate),
        .latch_counter(latch_counter),
        .frame_active (frame_active),
        .bit_index    (bit_index),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {ctr_reset,gate,latch,frame,bit_index,busy,done} for cycle c
    // after the start edge, for a gate window of w cycles.
    function automatic logic [10:0] exp_vec(input int c, input int w);
        logic [4:0] bi;
        bi = 5'd0;
        if (c >= 1 && c <= S)
            return {1'b1, 1'b0, 1'b0, 1'b0, bi, 1'b1, 1'b0};
        if (c >= S + 1 && c <= S + w)
            return {1'b0, 1'b1, 1'b0, 1'b0, bi, 1'b1, 1'b0};
        if (c >= S + w + 1 && c <= 2 * S + w)
            return {1'b0, 1'b0, 1'b0, 1'b0, bi, 1'b1, 1'b0};
        if (c == 2 * S + w + 1)
            return {1'b0, 1'b0, 1'b1, 1'b0, bi, 1'b1, 1'b0};
        if (c >= 2 * S + w + 2 && c <= 2 * S + w + F + 1) begin
            bi = 5'(2 * S + w + F + 1 - c);
            return {1'b0, 1'b0, 1'b0, 1'b1, bi, 1'b1, 1'b0};
        end
        if (c == 2 * S + w + F + 2)
            return {1'b0, 1'b0, 1'b0, 1'b0, bi, 1'b0, 1'b1};
        return 11'd0;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (obs !== 11'd0) begin
            errors++;
            $display("FAIL reset_hold: got %b want %b", obs, 11'd0);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (obs !== 11'd0) begin
            errors++;
            $display("FAIL reset_release: got %b want %b", obs, 11'd0);
        end
    endtask

    task automatic test_basic();
        window_sel = 2'd0;
        start = 1'b1;
        for (int c = 1; c <= 291; c++) begin
            tick();
            if (c == 1) start = 1'b0;
            checks++;
            if (obs !== exp_vec(c, 256)) begin
                errors++;
                $display("FAIL basic c=%0d: got %b want %b", c, obs, exp_vec(c, 256));
            end
        end
    endtask

    task automatic test_window3();
        window_sel = 2'd3;
        start = 1'b1;
        for (int c = 1; c <= 2 * S + 16384 + F + 3; c++) begin
            tick();
            if (c == 1) start = 1'b0;
            if (c == 10) window_sel = 2'd0;
            checks++;
            if (obs !== exp_vec(c, 16384)) begin
                errors++;
                $display("FAIL window3 c=%0d: got %b want %b", c, obs, exp_vec(c, 16384));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] e;
        window_sel = 2'd0;
        start = 1'b1;
        for (int c = 1; c <= 581; c++) begin
            tick();
            e = (c <= 290) ? exp_vec(c, 256) :
                (c <= 580) ? exp_vec(c - 290, 256) : exp_vec(c - 580, 256);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL b2b c=%0d: got %b want %b", c, obs, e);
            end
        end
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (obs !== 11'd0) begin
            errors++;
            $display("FAIL b2b_abort_clear: got %b want %b", obs, 11'd0);
        end
    endtask

    task automatic test_abort();
        window_sel = 2'd0;
        start = 1'b1;
        for (int c = 1; c <= 104; c++) begin
            tick();
            if (c == 1) start = 1'b0;
            checks++;
            if (obs !== exp_vec(c, 256)) begin
                errors++;
                $display("FAIL abort_pre c=%0d: got %b want %b", c, obs, exp_vec(c, 256));
            end
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (obs !== 11'd0) begin
            errors++;
            $display("FAIL abort_idle: got %b want %b", obs, 11'd0);
        end
        start = 1'b1;
        for (int c = 1; c <= 291; c++) begin
            tick();
            if (c == 1) start = 1'b0;
            checks++;
            if (obs !== exp_vec(c, 256)) begin
                errors++;
                $display("FAIL abort_restart c=%0d: got %b want %b", c, obs, exp_vec(c, 256));
            end
        end
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if (obs !== 11'd0) begin
            errors++;
            $display("FAIL abort_over_start: got %b want %b", obs, 11'd0);
        end
    endtask

    task automatic test_ena_pause();
        window_sel = 2'd0;
        start = 1'b1;
        for (int c = 1; c <= 277; c++) begin
            tick();
            if (c == 1) start = 1'b0;
            checks++;
            if (obs !== exp_vec(c, 256)) begin
                errors++;
                $display("FAIL ena_pre c=%0d: got %b want %b", c, obs, exp_vec(c, 256));
            end
        end
        checks++;
        if (bit_index !== 5'd12) begin
            errors++;
            $display("FAIL ena_bit_index: got %0d want %0d", bit_index, 12);
        end
        ena = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (obs !== exp_vec(277, 256)) begin
                errors++;
                $display("FAIL ena_hold k=%0d: got %b want %b", k, obs, exp_vec(277, 256));
            end
        end
        ena = 1'b1;
        for (int c = 278; c <= 291; c++) begin
            tick();
            checks++;
            if (obs !== exp_vec(c, 256)) begin
                errors++;
                $display("FAIL ena_post c=%0d: got %b want %b", c, obs, exp_vec(c, 256));
            end
        end
    endtask

    task automatic test_reset_mid_gate();
        logic seen_done;
        logic bad;
        window_sel = 2'd0;
        start = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            tick();
            if (c == 1) start = 1'b0;
        end
        checks++;
        if (gate !== 1'b1) begin
            errors++;
            $display("FAIL rstgate_pre: got gate=%b want 1", gate);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (obs !== 11'd0) begin
            errors++;
            $display("FAIL rstgate_now: got %b want %b", obs, 11'd0);
        end
        rst_n = 1'b1;
        seen_done = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (done) seen_done = 1'b1;
            if (obs !== 11'd0) bad = 1'b1;
        end
        checks++;
        if (seen_done !== 1'b0 || bad !== 1'b0) begin
            errors++;
            $display("FAIL rstgate_after: got done_seen=%b nonidle=%b want 0 0", seen_done, bad);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        ena = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        window_sel = 2'd0;
        test_reset();
        test_basic();
        test_window3();
        test_back_to_back();
        test_abort();
        test_ena_pause();
        test_reset_mid_gate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
